ram_port_arbiter: RTL

//  Two-requester round-robin arbiter and sequencer for the single-port synchronous RAM
//  (cs/we/address, bidirectional data bus, RAM samples on falling clk edge).

---
 rtl/ram_port_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port synchronous RAM.
// Port 0 is the processor data path; port 1 is the loader/debug path.
module ram_port_arbiter #(
  parameter int N     = 12,
  parameter int M     = 4,
  parameter int DEPTH = 4001
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         we0,
  input  logic [N-1:0] addr0,
  input  logic [M-1:0] wdata0,
  output logic         ack0,
  input  logic         req1,
  input  logic         we1,
  input  logic [N-1:0] addr1,
  input  logic [M-1:0] wdata1,
  output logic         ack1,
  output logic [M-1:0] rdata,
  output logic         err,
  output logic         busy,
  output logic         ram_cs,
  output logic         ram_we,
  output logic [N-1:0] ram_addr,
  inout  wire  [M-1:0] ram_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic           id_q, id_d;
  logic           we_q, we_d;
  logic           oor_q, oor_d;
  logic [M-1:0]   wdata_q, wdata_d;
  logic           ram_cs_q, ram_cs_d;
  logic           ram_we_q, ram_we_d;
  logic [N-1:0]   ram_addr_q, ram_addr_d;
  logic [M-1:0]   rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;

  logic           gnt1;
  logic           sel_we;
  logic [N-1:0]   sel_addr;
  logic [M-1:0]   sel_wdata;
  logic           sel_in_range;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    we_d       = we_q;
    oor_d      = oor_q;
    wdata_d    = wdata_q;
    ram_cs_d   = ram_cs_q;
    ram_we_d   = ram_we_q;
    ram_addr_d = ram_addr_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;

    // Port 1 wins when it is alone or when the pointer names it.
    gnt1         = req1 && (!req0 || ptr_q);
    sel_we       = gnt1 ? we1    : we0;
    sel_addr     = gnt1 ? addr1  : addr0;
    sel_wdata    = gnt1 ? wdata1 : wdata0;
    sel_in_range = (32'(sel_addr) < DEPTH);

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          id_d     = gnt1;
          ptr_d    = !gnt1;
          we_d     = sel_we;
          wdata_d  = sel_wdata;
          oor_d    = !sel_in_range;
          ram_cs_d = sel_in_range;
          ram_we_d = sel_in_range && sel_we;
          if (sel_in_range) ram_addr_d = sel_addr;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d  = (!we_q && !oor_q) ? ram_data : '0;
        err_d    = oor_q;
        ram_cs_d = 1'b0;
        ram_we_d = 1'b0;
        ack0_d   = !id_q;
        ack1_d   = id_q;
        state_d  = RESP;
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
    end
  end

  // NOTE: latched request fields need no reset; they are always loaded in IDLE before ACCESS reads them.
  always_ff @(posedge clk) begin
    id_q    <= id_d;
    we_q    <= we_d;
    oor_q   <= oor_d;
    wdata_q <= wdata_d;
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);
  assign ram_cs   = ram_cs_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;

  // Only write ACCESS cycles drive the bus; the RAM owns it for reads.
  assign ram_data = (ram_cs_q && ram_we_q) ? wdata_q : {M{1'bz}};

endmodule
